// File: rtl/uart_transmitter.sv
// uart_transmitter: buffered UART transmit stage.
// Words enter a small FIFO through a valid/ready handshake and are serialised
// as start bit, WIDTH data bits (LSB first) and STOP_BITS stop bits.
//
// state | meaning
// IDLE  | line high, counters cleared, waiting for a buffered word
// START | driving the start bit (0)
// DATA  | driving shift register bit 0, one data bit per baud period
// STOP  | driving stop bit(s) (1); pops the next word without an idle gap
module uart_transmitter #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             tx_data,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   output logic                         TXserial,
   output logic                         busy,
   output logic                         tx_done,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]       state_q,  state_d;
   logic [BW-1:0]    baud_q,   baud_d;
   logic [IW-1:0]    bit_q,    bit_d;
   logic             stop_q,   stop_d;
   logic [WIDTH-1:0] shift_q,  shift_d;
   logic             tx_q,     tx_d;
   logic             done_q,   done_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic push;
   logic pop;
   logic baud_wrap;
   logic have_word;

   assign tx_ready   = (count_q != COUNT_FULL);
   assign push       = tx_valid && tx_ready;
   assign baud_wrap  = (baud_q == BAUD_LAST);
   assign have_word  = (count_q != '0);

   assign TXserial   = tx_q;
   assign busy       = (state_q != IDLE);
   assign tx_done    = done_q;
   assign fifo_count = count_q;

   // FIFO storage and pointer/occupancy bookkeeping.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = tx_data;
      end
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Framing FSM; the line value is computed for the next state so TXserial is a flop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            if (have_word) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_wrap) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
                  stop_d  = 1'b0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_d[0];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (stop_q == STOP_LAST) begin
                  done_d = 1'b1;
                  stop_d = 1'b0;
                  if (have_word) begin
                     // Chain straight into the next start bit.
                     pop     = 1'b1;
                     shift_d = mem_q[rd_ptr_q];
                     state_d = START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State registers; reset abandons any frame and discards buffered words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: main instance at CLKS_PER_BIT=4/STOP_BITS=1,
// second instance at CLKS_PER_BIT=1/STOP_BITS=2. Accepted words go into a
// scoreboard queue; the frame receiver pops and compares them cycle by cycle.
module tb_uart_transmitter;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int STOPB = 1;
   localparam int FRAME = (1 + WIDTH + STOPB) * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, TXserial, busy, tx_done;
   logic [2:0] fifo_count;

   logic [7:0] tx_data2 = 8'h00;
   logic       tx_valid2 = 1'b0;
   logic       tx_ready2, TXserial2, busy2, tx_done2;
   logic [2:0] fifo_count2;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb_q[$];

   uart_transmitter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .TXserial(TXserial), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count));

   uart_transmitter #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
      .TXserial(TXserial2), .busy(busy2), .tx_done(tx_done2), .fifo_count(fifo_count2));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pushes one word; leaves tx_valid high so consecutive calls push on consecutive edges.
   task automatic push_word(input logic [7:0] d, output int stalls);
      stalls = 0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && stalls < 500) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 500) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: tx_ready=%b required 1 within 500 cycles", tx_ready);
      end
      sb_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   // Receives one frame. chained=1 means the current negedge is already the first start cycle.
   task automatic recv_frame(input bit chained);
      logic [7:0] w;
      logic [9:0] bits;
      logic       exp_done;
      int t;
      if (!chained) begin
         t = 0;
         @(negedge clk);
         while (TXserial !== 1'b0 && t < 300) begin
            t++;
            @(negedge clk);
         end
         checks++;
         if (TXserial !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: TXserial=%b required 0 within 300 cycles", TXserial);
            return;
         end
      end else begin
         checks++;
         if (TXserial !== 1'b0) begin
            errors++;
            $display("FAIL no_gap: TXserial=%b required 0 right after tx_done", TXserial);
         end
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: frame started with scoreboard size 0 required >0");
         return;
      end
      w    = sb_q.pop_front();
      bits = {1'b1, w, 1'b0};
      for (int c = 0; c < FRAME; c++) begin
         if (c > 0) @(negedge clk);
         exp_done = chained && (c == 0);
         checks++;
         if (TXserial !== bits[c/CPB] || tx_done !== exp_done || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_bit word=%h cycle=%0d: TXserial=%b tx_done=%b busy=%b required %b %b 1",
                     w, c, TXserial, tx_done, busy, bits[c/CPB], exp_done);
         end
      end
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b1) begin
         errors++;
         $display("FAIL tx_done_pulse word=%h: tx_done=%b required 1", w, tx_done);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #2;
      checks++; if (TXserial !== 1'b1) begin errors++; $display("FAIL rst_txserial: %b required 1", TXserial); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: %b required 1", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_tx_done: %b required 0", tx_done); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count: %0d required 0", fifo_count); end
      checks++; if (TXserial2 !== 1'b1 || busy2 !== 1'b0 || fifo_count2 !== 3'd0 || tx_ready2 !== 1'b1) begin
         errors++; $display("FAIL rst_dut2: TXserial=%b busy=%b count=%0d ready=%b required 1 0 0 1",
                            TXserial2, busy2, fifo_count2, tx_ready2);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (TXserial !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: TXserial=%b busy=%b required 1 0", TXserial, busy);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      sb_q.push_back(8'hA5);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      checks++; if (fifo_count !== 3'd1 || TXserial !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_push_edge: count=%0d TXserial=%b busy=%b required 1 1 0",
                            fifo_count, TXserial, busy);
      end
      @(posedge clk);
      #1;
      checks++; if (fifo_count !== 3'd0 || TXserial !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_pop_edge: count=%0d TXserial=%b busy=%b required 0 0 1",
                            fifo_count, TXserial, busy);
      end
      recv_frame(1'b0);
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0 || TXserial !== 1'b1) begin
         errors++; $display("FAIL single_end: busy=%b count=%0d TXserial=%b required 0 0 1",
                            busy, fifo_count, TXserial);
      end
      @(negedge clk);
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL single_done_width: tx_done=%b required 0", tx_done); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [4];
      words = '{8'h00, 8'hFF, 8'h3C, 8'h81};
      fork
         begin
            int st;
            for (int i = 0; i < 4; i++) begin
               push_word(words[i], st);
               checks++;
               if (st != 0) begin
                  errors++; $display("FAIL b2b_ready word %0d: stalled %0d cycles required 0", i, st);
               end
            end
            tx_valid = 1'b0;
         end
         begin
            recv_frame(1'b0);
            for (int i = 0; i < 3; i++) recv_frame(1'b1);
         end
      join
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL b2b_end: busy=%b count=%0d required 0 0", busy, fifo_count);
      end
      @(negedge clk);
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL b2b_extra_done: tx_done=%b required 0", tx_done); end
   endtask

   task automatic test_fifo_full();
      int total_stalls = 0;
      int maxc = 0;
      int bad = 0;
      fork
         begin
            int st;
            for (int i = 0; i < 6; i++) begin
               push_word(8'(8'h11 * (i + 1)), st);
               total_stalls += st;
            end
            tx_valid = 1'b0;
         end
         begin
            recv_frame(1'b0);
            for (int i = 0; i < 5; i++) recv_frame(1'b1);
         end
         begin
            for (int i = 0; i < 6 * FRAME + 20; i++) begin
               @(negedge clk);
               if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
               if ((fifo_count == 3'd4) && (tx_ready !== 1'b0)) bad++;
               if ((fifo_count != 3'd4) && (tx_ready !== 1'b1)) bad++;
            end
         end
      join
      checks++; if (maxc != DEPTH) begin errors++; $display("FAIL full_max_count: %0d required %0d", maxc, DEPTH); end
      checks++; if (bad != 0) begin errors++; $display("FAIL full_ready: %0d bad cycles required 0", bad); end
      checks++; if (total_stalls == 0) begin errors++; $display("FAIL full_stall: stalls=%0d required >0", total_stalls); end
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL full_end: busy=%b count=%0d required 0 0", busy, fifo_count);
      end
   endtask

   task automatic test_simultaneous();
      fork
         begin
            int st;
            push_word(8'h12, st);
            push_word(8'h34, st);
            push_word(8'h56, st);
            tx_valid = 1'b0;
            repeat (38) @(posedge clk);
            @(negedge clk);
            checks++; if (fifo_count !== 3'd2) begin
               errors++; $display("FAIL simul_pre_count: %0d required 2", fifo_count);
            end
            tx_valid = 1'b1;
            tx_data  = 8'h78;
            sb_q.push_back(8'h78);
            @(posedge clk);
            #1 tx_valid = 1'b0;
            checks++; if (fifo_count !== 3'd2 || tx_done !== 1'b1) begin
               errors++; $display("FAIL simul_post: count=%0d tx_done=%b required 2 1", fifo_count, tx_done);
            end
         end
         begin
            recv_frame(1'b0);
            for (int i = 0; i < 3; i++) recv_frame(1'b1);
         end
      join
   endtask

   task automatic test_reset_mid();
      int st;
      int bad = 0;
      push_word(8'hA5, st);
      push_word(8'h11, st);
      push_word(8'h22, st);
      tx_valid = 1'b0;
      repeat (16) @(posedge clk);
      #3;
      checks++; if (TXserial !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_pre_reset: TXserial=%b busy=%b required 0 1 (data bit 3)", TXserial, busy);
      end
      reset = 1'b1;
      #1;
      checks++; if (TXserial !== 1'b1) begin errors++; $display("FAIL mid_txserial: %b required 1", TXserial); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: %0d required 0", fifo_count); end
      checks++; if (busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) begin
         errors++; $display("FAIL mid_flags: busy=%b tx_done=%b ready=%b required 0 0 1", busy, tx_done, tx_ready);
      end
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || TXserial !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet: %0d active cycles after reset required 0", bad); end
      push_word(8'h5A, st);
      tx_valid = 1'b0;
      recv_frame(1'b0);
   endtask

   task automatic test_params();
      logic [10:0] exp2;
      exp2 = 11'b110_0000_0010;
      @(negedge clk);
      tx_valid2 = 1'b1;
      tx_data2  = 8'h01;
      @(posedge clk);
      #1 tx_valid2 = 1'b0;
      checks++; if (fifo_count2 !== 3'd1) begin errors++; $display("FAIL p2_count: %0d required 1", fifo_count2); end
      for (int c = 0; c < 11; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (TXserial2 !== exp2[c] || tx_done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++; $display("FAIL p2_bit cycle=%0d: TXserial=%b tx_done=%b busy=%b required %b 0 1",
                               c, TXserial2, tx_done2, busy2, exp2[c]);
         end
      end
      @(posedge clk);
      #1;
      checks++; if (tx_done2 !== 1'b1 || busy2 !== 1'b0 || TXserial2 !== 1'b1) begin
         errors++; $display("FAIL p2_done: tx_done=%b busy=%b TXserial=%b required 1 0 1", tx_done2, busy2, TXserial2);
      end
      @(posedge clk);
      #1;
      checks++; if (tx_done2 !== 1'b0) begin errors++; $display("FAIL p2_done_width: %b required 0", tx_done2); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_simultaneous();
      test_reset_mid();
      test_params();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d words untransmitted required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART. Accepts parallel words through a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and drives them onto TXserial. Each frame is one start bit (0), WIDTH data bits LSB first, and STOP_BITS stop bits (1). This stream is the one the UART receiver consumes. Bit timing comes from an internal divider, so each serial bit lasts CLKS_PER_BIT clock cycles.

## Interface
- WIDTH, 8: data bits per frame.
- DEPTH, 4: TX FIFO entries; DEPTH ≥ 2, power of two.
- CLKS_PER_BIT, 16: clock cycles per serial bit; ≥ 1.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- tx_data  input  WIDTH  word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept a word (count < DEPTH).
- TXserial  output  1  serial line, idle high, registered.
- busy  output  1  FSM not in IDLE.
- tx_done  output  1  one-cycle pulse at end of each frame.
- fifo_count  output  $clog2(DEPTH+1)  words currently buffered.

## Operation
- Push: on a clk edge with tx_valid && tx_ready, tx_data is written at the write pointer, and the pointer increments mod DEPTH. tx_valid while tx_ready = 0 is ignored; there is no overflow. The source holds the word until accepted.
- tx_ready = (fifo_count != DEPTH), combinational from count.
- Pop: occurs only when the FSM leaves IDLE or STOP into START. The head word is loaded into the shift register, and the read pointer increments mod DEPTH.
- fifo_count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Push at full is impossible. Pop at empty does not occur.
- FSM states IDLE, START, DATA, STOP. Baud counter is 0..CLKS_PER_BIT-1. Bit index is 0..WIDTH-1. Stop index is 0..STOP_BITS-1.
  - IDLE: TXserial = 1, counters cleared. If fifo_count > 0: pop, go to START.
  - START: TXserial = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXserial = shift[0] for CLKS_PER_BIT cycles. Then shift right and increment the bit index. After bit WIDTH-1, go to STOP.
  - STOP: TXserial = 1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, pulse tx_done. If fifo_count > 0, pop and go directly to START with no idle gap; else go to IDLE.
- busy = (state != IDLE).
- Reset mid-frame immediately forces the following:
  - TXserial = 1, state IDLE, all counters and pointers 0.
  - fifo_count = 0; buffered words are discarded.
  - tx_done = 0.
  - The partial frame is abandoned; no completion is signalled.

## Timing
- Reset values: TXserial = 1, tx_ready = 1, busy = 0, tx_done = 0, fifo_count = 0.
- Empty and idle, word pushed at edge k:
  - fifo_count = 1 after edge k.
  - Pop at edge k+1: TXserial = 0 and busy = 1 from edge k+1.
- Frame length: (1 + WIDTH + STOP_BITS) × CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- tx_done is high for exactly the one cycle following the last stop-bit cycle. That cycle is the first cycle of the next start bit if back-to-back, otherwise the first IDLE cycle.
- Back-to-back frames: the stop bit of frame n is followed immediately by the start bit of frame n+1.
- Throughput: at most one word popped per frame. With a full FIFO, tx_ready rises in the cycle after the pop edge.
- TXserial changes only on the baud-counter wrap or a state entry, and is glitch-free (registered).

## Test plan
- Single word: CLKS_PER_BIT=4, STOP_BITS=1, push 0xA5. Required response:
  - TXserial = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - tx_done pulses once at cycle 40.
  - busy then drops and fifo_count returns to 0.
- Back-to-back: push 0x00, 0xFF, 0x3C, 0x81 on consecutive cycles. Required response:
  - tx_ready stays 1 throughout; it never blocks, because the first word is popped at k+1.
  - Four contiguous 40-cycle frames with no high gap between the stop bit and the next start bit.
  - Exactly 4 tx_done pulses.
- FIFO full: hold tx_valid = 1 with 6 distinct words. Required response:
  - fifo_count reaches 4 and tx_ready = 0 while full.
  - The stalled word is not lost, and each accept follows a pop.
  - All 6 words are transmitted in order.
- Simultaneous push and pop: push exactly on the STOP→START pop edge with count = 2. Required response: fifo_count stays 2.
- Reset mid-frame: with 3 words queued, assert reset during DATA bit 3. Required response:
  - TXserial = 1 asynchronously, fifo_count = 0, busy = 0.
  - No tx_done after reset.
  - After release, push 0x5A; its frame is transmitted cleanly.
- Parameters CLKS_PER_BIT=1, STOP_BITS=2: push 0x01. Required response:
  - TXserial = 0,1,0,0,0,0,0,0,0,1,1, one cycle each.
  - tx_done at cycle 11.
